pcf8591_scan_ctrl: RTL and testbench
====================================

# pcf8591_scan_ctrl

- Sequences the PCF8591 byte reader `ad` through analog inputs AIN0–AIN3 on a fixed scan period.
- Discards the stale first byte the PCF8591 returns after each control-word change.
- Keeps the latest 8-bit result per channel in registers for `lcd1602` and `esp8266_encode`.
- Sits between `top` and `ad`: it owns `ad`'s control word and request, and nothing else drives them.

## Interface
Parameters:
- `SCAN_DIV`, 500_000: cycles between scan starts, start-to-start (10 ms at 50 MHz); legal range ≥ 16.
- `TIMEOUT`, 2_000_000: cycles to wait for `adc_done` after a request before abandoning it.
- `DISCARD`, 1: reads thrown away after a channel change (0–3).

Ports:
- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: reset; synchronous, active-high.
- `enable` in 1: run scanning.
- `ch_mask` in 4: bit n enables AINn.
- `adc_req` out 1: one-cycle read request to `ad`.
- `adc_ctrl` out 8: PCF8591 control word, {6'b0, ch}. Auto-increment and analog output are always off.
- `adc_done` in 1: one-cycle pulse from `ad`; `adc_data` is valid in the same cycle.
- `adc_data` in 8: conversion byte.
- `ch_data` out 32: AINn result at [8n+7:8n].
- `ch_valid` out 4: bit n sticky high after the first stored AINn result.
- `sample_stb` out 1: one-cycle pulse when any `ch_data` byte updates.
- `sample_ch` out 2: channel updated at `sample_stb`.
- `scan_done` out 1: one-cycle pulse at the end of each scan.
- `timeout_err` out 1: sticky high once any request times out.

## Operation
States: IDLE, WAIT_TICK, ISSUE, WAIT_DONE, STORE, NEXT.
- **IDLE:** stays here while `enable`=0 or `ch_mask`=0. Otherwise latches `ch_mask` into `mask_q` and goes to ISSUE on the lowest set channel.
- **ISSUE (1 cycle):**
  - asserts `adc_req`;
  - drives `adc_ctrl`={6'b0,ch};
  - loads `disc_cnt`=DISCARD if ch ≠ `last_ch` or `first_flag`=1; otherwise keeps it;
  - updates `last_ch`, clears `first_flag`, clears the timeout counter;
  - goes to WAIT_DONE.
- **WAIT_DONE:**
  - on `adc_done` with `disc_cnt`>0: decrement `disc_cnt`, return to ISSUE (byte discarded);
  - on `adc_done` with `disc_cnt`=0: go to STORE;
  - if the timeout counter reaches TIMEOUT−1 with no `adc_done`: set `timeout_err`, go to NEXT, no store.
- **STORE (1 cycle):** writes the captured byte to `ch_data[ch]`, sets `ch_valid[ch]`, pulses `sample_stb` with `sample_ch`=ch, goes to NEXT.
- **NEXT:**
  - if a higher channel is set in `mask_q`: go to ISSUE on it;
  - otherwise pulse `scan_done`; go to IDLE if `enable`=0, else to WAIT_TICK.
- **WAIT_TICK:** waits for the period tick, relatches `ch_mask`, goes to ISSUE. If the latched mask is 0, goes to IDLE instead.
- **Period counter:** free-runs 0..SCAN_DIV−1 while `enable`=1 and raises the tick at wrap.
  - The tick is held pending until WAIT_TICK consumes it.
  - A scan longer than SCAN_DIV therefore restarts the cycle after NEXT, and at most one tick is pending.
- **Boundaries:**
  - `enable` dropping mid-transaction: the current request completes (done or timeout), then the block goes to IDLE. No request is ever abandoned early.
  - `adc_done` outside WAIT_DONE is ignored.
  - `ch_mask` changes take effect only at scan start.
  - With a single-channel mask, the discard happens only on the first visit after reset.
  - `rst` at any time, including mid-I2C: the block returns to IDLE next cycle. `ad` has its own reset.

## Timing
- Reset values:
  - `adc_req`=0, `adc_ctrl`=0, `ch_data`=0, `ch_valid`=0;
  - `sample_stb`=0, `sample_ch`=0, `scan_done`=0, `timeout_err`=0;
  - `last_ch`=0, `first_flag`=1, period counter=0.
- First request comes 1 cycle after IDLE sees `enable`=1 with a nonzero mask.
- `adc_ctrl` is registered and stable from the ISSUE cycle until the matching `adc_done`.
- `adc_data` is captured on the `adc_done` cycle. `ch_data` and `sample_stb` change 1 cycle later (STORE).
- Consecutive reads: `adc_done` to the next `adc_req` is 1 cycle (the ISSUE state entry).
- Timeout counter is 21 bits and saturates. The error is flagged exactly TIMEOUT cycles after `adc_req`.
- `scan_done` comes 1 cycle after the last STORE (or the last timeout).

## Structure
- Shared package `pcf8591_pkg`:
  - state encoding (3-bit localparams);
  - `PCF_CTRL_AIN0`..`PCF_CTRL_AIN3` = 8'h00..8'h03.
- One sub-module, `scan_tick_gen`: the period counter plus pending-tick flag, parameter SCAN_DIV.
- Next-channel search is a combinational priority encoder over `mask_q` above the current channel. It stays inline.

## Test plan
- **Single channel:** `ad` model returns the previous byte, then 8'h7F; `ch_mask`=4'b0001, DISCARD=1. Required: two `adc_req`, `ch_data[7:0]`=8'h7F, `ch_valid`=4'b0001, one `sample_stb` with `sample_ch`=0.
- **Full scan:** `ch_mask`=4'b1111, model returns 8'h10+ch. Required:
  - `adc_ctrl` sequence 00,00,01,01,02,02,03,03;
  - `ch_data`=32'h13121110;
  - `scan_done` 1 cycle after the ch3 STORE.
- **Sparse mask and mask change:** `ch_mask`=4'b1010, then changed to 4'b0001 mid-scan. Required: current scan visits only AIN1 and AIN3; the next scan visits only AIN0.
- **Timeout:** TIMEOUT=100, AIN2 never answers. Required:
  - `timeout_err` rises exactly 100 cycles after its `adc_req`;
  - `ch_data[23:16]` unchanged;
  - AIN3 still sampled.
- **Period:** SCAN_DIV=1000. Required: scan starts 1000 cycles apart. When the model delays each read by 400 cycles, the next scan starts 1 cycle after `scan_done`.
- **Reset and disable:** `rst` pulsed during WAIT_DONE. Required: all outputs at reset values next cycle, and the discard is redone on restart. `enable` dropped mid-read: the pending read completes, then no further `adc_req`.

Source files
------------

// File: rtl/pcf8591_pkg.sv
// Shared definitions for the PCF8591 scan controller.
//   state_t        : scan FSM state encoding (3 bits, also exported on dbg_state)
//   PCF_CTRL_AINn  : PCF8591 control words, single-ended, no auto-increment,
//                    analog output disabled
//   lowest_ch()    : lowest enabled channel of a 4-bit mask
//   ctrl_word()    : control word for a channel number
package pcf8591_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_TICK = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_STORE     = 3'd4,
    S_NEXT      = 3'd5
  } state_t;

  localparam logic [7:0] PCF_CTRL_AIN0 = 8'h00;
  localparam logic [7:0] PCF_CTRL_AIN1 = 8'h01;
  localparam logic [7:0] PCF_CTRL_AIN2 = 8'h02;
  localparam logic [7:0] PCF_CTRL_AIN3 = 8'h03;

  localparam int TMO_W = 21;

  function automatic logic [1:0] lowest_ch(input logic [3:0] mask);
    lowest_ch = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) lowest_ch = 2'(i);
    end
  endfunction

  function automatic logic [7:0] ctrl_word(input logic [1:0] ch);
    case (ch)
      2'd0:    ctrl_word = PCF_CTRL_AIN0;
      2'd1:    ctrl_word = PCF_CTRL_AIN1;
      2'd2:    ctrl_word = PCF_CTRL_AIN2;
      default: ctrl_word = PCF_CTRL_AIN3;
    endcase
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Scan period generator.
//   clk, rst      : clock, synchronous active-high reset
//   enable        : counter runs 0..SCAN_DIV-1 while high, held at 0 otherwise
//   consume       : scan FSM has used the pending tick
//   tick_pending  : a period boundary has passed and not yet been consumed
// At most one tick is remembered; a scan overrunning the period simply
// starts the next one as soon as it finishes.
module scan_tick_gen #(
  parameter int SCAN_DIV = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic consume,
  output logic tick_pending
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0] cnt_q;
  logic          wrap;

  assign wrap = enable && (cnt_q == CW'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      tick_pending <= 1'b0;
    end else begin
      if (!enable || wrap) cnt_q <= '0;
      else                 cnt_q <= cnt_q + 1'b1;
      // A fresh wrap wins over a same-cycle consume: the new tick is real.
      if (wrap)         tick_pending <= 1'b1;
      else if (consume) tick_pending <= 1'b0;
    end
  end

endmodule

// File: rtl/pcf8591_scan_ctrl.sv
// PCF8591 channel scanner: walks AIN0..AIN3 (per ch_mask) once per scan
// period through the `ad` byte reader, drops the stale byte after each
// control-word change and keeps the latest byte per channel.
//   clk, rst     : 50 MHz clock, synchronous active-high reset
//   enable       : run scanning
//   ch_mask      : bit n enables AINn, sampled at scan start only
//   adc_req      : one-cycle read request to `ad`
//   adc_ctrl     : PCF8591 control word {6'b0, ch}
//   adc_done     : one-cycle completion from `ad`, adc_data valid with it
//   adc_data     : conversion byte
//   ch_data      : AINn result at [8n+7:8n]
//   ch_valid     : sticky, AINn has been stored at least once
//   sample_stb   : one-cycle pulse when a ch_data byte updates
//   sample_ch    : channel of the update
//   scan_done    : one-cycle pulse at the end of each scan
//   timeout_err  : sticky, some request went unanswered
//   dbg_state    : current FSM state
//
// Handshake with `ad`: adc_req is high for exactly the ISSUE cycle and
// adc_ctrl holds steady from then until the matching adc_done. Only one
// request is ever outstanding; adc_done is honoured only in WAIT_DONE and
// ignored in every other state.
module pcf8591_scan_ctrl
  import pcf8591_pkg::*;
#(
  parameter int SCAN_DIV = 500_000,
  parameter int TIMEOUT  = 2_000_000,
  parameter int DISCARD  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [3:0]  ch_mask,
  output logic        adc_req,
  output logic [7:0]  adc_ctrl,
  input  logic        adc_done,
  input  logic [7:0]  adc_data,
  output logic [31:0] ch_data,
  output logic [3:0]  ch_valid,
  output logic        sample_stb,
  output logic [1:0]  sample_ch,
  output logic        scan_done,
  output logic        timeout_err,
  output logic [2:0]  dbg_state
);

  state_t             state_q, state_d;
  logic [3:0]         mask_q;
  logic [1:0]         ch_q, ch_d;
  logic [1:0]         last_ch;
  logic               first_flag;
  logic [1:0]         disc_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               tick_pending, tick_consume, load_mask;
  logic               has_next;
  logic [1:0]         next_ch;
  logic               tmo_hit, store_hit;

  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .consume      (tick_consume),
    .tick_pending (tick_pending)
  );

  // Lowest enabled channel strictly above the current one.
  always_comb begin
    has_next = 1'b0;
    next_ch  = ch_q;
    for (int i = 3; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(ch_q))) begin
        has_next = 1'b1;
        next_ch  = 2'(i);
      end
    end
  end

  // tmo_cnt is 0 in the ISSUE cycle, so this fires in the last WAIT_DONE
  // cycle and timeout_err shows up exactly TIMEOUT cycles after adc_req.
  assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign store_hit = (state_q == S_WAIT_DONE) && adc_done && (disc_cnt == 2'd0);

  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    load_mask    = 1'b0;
    tick_consume = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable && (ch_mask != 4'd0)) begin
          load_mask    = 1'b1;
          tick_consume = 1'b1;
          ch_d         = lowest_ch(ch_mask);
          state_d      = S_ISSUE;
        end
      end
      S_WAIT_TICK: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (tick_pending) begin
          load_mask    = 1'b1;
          tick_consume = 1'b1;
          if (ch_mask == 4'd0) begin
            state_d = S_IDLE;
          end else begin
            ch_d    = lowest_ch(ch_mask);
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (adc_done) begin
          if (disc_cnt != 2'd0) state_d = enable ? S_ISSUE : S_IDLE;
          else                  state_d = S_STORE;
        end else if (tmo_hit) begin
          state_d = S_NEXT;
        end
      end
      S_STORE: state_d = S_NEXT;
      S_NEXT: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (has_next) begin
          ch_d    = next_ch;
          state_d = S_ISSUE;
        end else if (tick_pending) begin
          // Overrunning scan: the tick is already here, so restart straight
          // away instead of spending a cycle in WAIT_TICK.
          load_mask    = 1'b1;
          tick_consume = 1'b1;
          if (ch_mask == 4'd0) begin
            state_d = S_IDLE;
          end else begin
            ch_d    = lowest_ch(ch_mask);
            state_d = S_ISSUE;
          end
        end else begin
          state_d = S_WAIT_TICK;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mask_q      <= 4'd0;
      ch_q        <= 2'd0;
      last_ch     <= 2'd0;
      first_flag  <= 1'b1;
      disc_cnt    <= 2'd0;
      tmo_cnt     <= '0;
      ch_data     <= 32'd0;
      ch_valid    <= 4'd0;
      timeout_err <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      if (load_mask) mask_q <= ch_mask;

      // The discard budget is reloaded only when the control word changes;
      // re-issues on the same channel keep counting it down.
      if (state_q == S_ISSUE) begin
        if ((ch_q != last_ch) || first_flag) disc_cnt <= 2'(DISCARD);
        last_ch    <= ch_q;
        first_flag <= 1'b0;
      end else if ((state_q == S_WAIT_DONE) && adc_done && (disc_cnt != 2'd0)) begin
        disc_cnt <= disc_cnt - 2'd1;
      end

      if (state_d == S_ISSUE)  tmo_cnt <= '0;
      else if (tmo_cnt != '1)  tmo_cnt <= tmo_cnt + 1'b1;

      // Byte is written on the adc_done edge so ch_data and sample_stb
      // both change in the STORE cycle.
      if (store_hit) begin
        for (int n = 0; n < 4; n++) begin
          if (ch_q == 2'(n)) begin
            ch_data[8*n +: 8] <= adc_data;
            ch_valid[n]       <= 1'b1;
          end
        end
      end

      if ((state_q == S_WAIT_DONE) && !adc_done && tmo_hit) timeout_err <= 1'b1;
    end
  end

  assign adc_req    = (state_q == S_ISSUE);
  assign adc_ctrl   = ctrl_word(ch_q);
  assign sample_stb = (state_q == S_STORE);
  assign sample_ch  = ch_q;
  assign scan_done  = (state_q == S_NEXT) && !has_next;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_pcf8591_scan_ctrl.sv
module tb_pcf8591_scan_ctrl;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst, enable, adc_done, adc_req, sample_stb, scan_done, timeout_err;
  logic [3:0]  ch_mask, ch_valid;
  logic [7:0]  adc_ctrl, adc_data;
  logic [31:0] ch_data;
  logic [1:0]  sample_ch;
  logic [2:0]  dbg_state;

  pcf8591_scan_ctrl #(.SCAN_DIV(1000), .TIMEOUT(100), .DISCARD(1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .ch_mask(ch_mask),
    .adc_req(adc_req), .adc_ctrl(adc_ctrl), .adc_done(adc_done), .adc_data(adc_data),
    .ch_data(ch_data), .ch_valid(ch_valid), .sample_stb(sample_stb), .sample_ch(sample_ch),
    .scan_done(scan_done), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // Second instance with a slow `ad` for the scan-overrun case.
  logic        rst_b, enable_b, adc_done_b, adc_req_b, sample_stb_b, scan_done_b, timeout_err_b;
  logic [3:0]  ch_mask_b, ch_valid_b;
  logic [7:0]  adc_ctrl_b, adc_data_b;
  logic [31:0] ch_data_b;
  logic [1:0]  sample_ch_b;
  logic [2:0]  dbg_state_b;

  pcf8591_scan_ctrl #(.SCAN_DIV(1000), .TIMEOUT(2000), .DISCARD(1)) dut_b (
    .clk(clk), .rst(rst_b), .enable(enable_b), .ch_mask(ch_mask_b),
    .adc_req(adc_req_b), .adc_ctrl(adc_ctrl_b), .adc_done(adc_done_b), .adc_data(adc_data_b),
    .ch_data(ch_data_b), .ch_valid(ch_valid_b), .sample_stb(sample_stb_b), .sample_ch(sample_ch_b),
    .scan_done(scan_done_b), .timeout_err(timeout_err_b), .dbg_state(dbg_state_b)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_checks++;
    n_errors++;
    $display("FAIL %s: %s", name, what);
  endtask

  // ---------------- `ad` models ----------------
  // Model A: latency lat_a cycles; the first read after a control-word
  // change returns the stale byte 8'hEE, later reads return vals[ch].
  int         lat_a   = 3;
  int         mute_ch = -1;
  int         inj_req = 0;
  logic [7:0] vals [4];

  initial begin : ad_model_a
    int         cnt;
    int         inj_seen;
    logic [7:0] cur_ctrl;
    logic [7:0] last_ctrl;
    cnt = 0; inj_seen = 0; cur_ctrl = 8'h00; last_ctrl = 8'hFF;
    adc_done = 1'b0; adc_data = 8'h00;
    forever begin
      @(negedge clk);
      adc_done = 1'b0;
      if (rst) begin
        cnt = 0;
        last_ctrl = 8'hFF;
      end else if (adc_req) begin
        cnt = lat_a;
        cur_ctrl = adc_ctrl;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0 && int'(cur_ctrl[1:0]) != mute_ch) begin
          adc_done = 1'b1;
          adc_data = (cur_ctrl == last_ctrl) ? vals[cur_ctrl[1:0]] : 8'hEE;
          last_ctrl = cur_ctrl;
        end
      end else if (inj_req != inj_seen) begin
        inj_seen = inj_req;
        adc_done = 1'b1;
        adc_data = 8'hA5;
      end
    end
  end

  // Model B: every read takes 400 cycles and returns 8'h60.
  initial begin : ad_model_b
    int cnt;
    cnt = 0;
    adc_done_b = 1'b0; adc_data_b = 8'h00;
    forever begin
      @(negedge clk);
      adc_done_b = 1'b0;
      if (rst_b) cnt = 0;
      else if (adc_req_b) cnt = 400;
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          adc_done_b = 1'b1;
          adc_data_b = 8'h60;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_ctrl_q[$];
  logic [9:0] exp_smp_q[$];   // {channel, byte}
  int n_req = 0;
  int last_stb_cyc = 0;

  initial begin : monitor
    logic [7:0] e_ctrl;
    logic [9:0] e_smp;
    logic [7:0] got_byte;
    forever begin
      @(negedge clk);
      if (adc_req) begin
        n_req++;
        if (exp_ctrl_q.size() == 0) fail_now("unexpected_req", $sformatf("adc_ctrl=%0h", adc_ctrl));
        else begin
          e_ctrl = exp_ctrl_q.pop_front();
          check("adc_ctrl", 32'(adc_ctrl), 32'(e_ctrl));
        end
      end
      if (sample_stb) begin
        last_stb_cyc = cyc;
        got_byte = 8'(ch_data >> (8 * sample_ch));
        if (exp_smp_q.size() == 0) fail_now("unexpected_sample", $sformatf("ch=%0d byte=%0h", sample_ch, got_byte));
        else begin
          e_smp = exp_smp_q.pop_front();
          check("sample_ch_byte", {22'd0, sample_ch, got_byte}, {22'd0, e_smp});
          check("sample_ch_valid", 32'(ch_valid[sample_ch]), 32'd1);
        end
      end
    end
  end

  // ---------------- driver / wait tasks ----------------
  task automatic tick_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int limit, output int c);
    c = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (adc_req) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) fail_now("wait_req", $sformatf("no adc_req within %0d cycles", limit));
  endtask

  task automatic wait_scan_done(input int limit, output int c);
    c = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (scan_done) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) fail_now("wait_scan_done", $sformatf("no scan_done within %0d cycles", limit));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_adc_req"},     32'(adc_req), 32'd0);
    check({tag, "_adc_ctrl"},    32'(adc_ctrl), 32'd0);
    check({tag, "_ch_data"},     ch_data, 32'd0);
    check({tag, "_ch_valid"},    32'(ch_valid), 32'd0);
    check({tag, "_sample_stb"},  32'(sample_stb), 32'd0);
    check({tag, "_sample_ch"},   32'(sample_ch), 32'd0);
    check({tag, "_scan_done"},   32'(scan_done), 32'd0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    check({tag, "_state_idle"},  32'(dbg_state), 32'd0);
  endtask

  task automatic push_ctrl(input logic [7:0] c, input int times);
    for (int i = 0; i < times; i++) exp_ctrl_q.push_back(c);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stimulus
    int c1, c2, sd, t0;
    bit seen;
    rst = 1'b1; enable = 1'b0; ch_mask = 4'd0;
    rst_b = 1'b1; enable_b = 1'b0; ch_mask_b = 4'd0;
    for (int i = 0; i < 4; i++) vals[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset("reset");

    // Single channel: stale byte discarded, 8'h7F stored.
    vals[0] = 8'h7F;
    push_ctrl(8'h00, 2);
    exp_smp_q.push_back({2'd0, 8'h7F});
    t0 = n_req;
    tick_drive(); ch_mask = 4'b0001; enable = 1'b1;
    wait_scan_done(100, sd);
    tick_drive(); enable = 1'b0;
    @(negedge clk);
    check("single_req_count", 32'(n_req - t0), 32'd2);
    check("single_ch_valid", 32'(ch_valid), 32'h1);
    check("single_ch_data0", 32'(ch_data[7:0]), 32'h7F);

    // Full scan from a fresh reset.
    tick_drive(); rst = 1'b1;
    tick_drive(); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vals[i] = 8'h10 + 8'(i);
      push_ctrl(8'(i), 2);
      exp_smp_q.push_back({2'(i), 8'h10 + 8'(i)});
    end
    tick_drive(); ch_mask = 4'b1111; enable = 1'b1;
    wait_scan_done(300, sd);
    check("full_scan_done_gap", 32'(sd - last_stb_cyc), 32'd1);
    tick_drive(); enable = 1'b0;
    @(negedge clk);
    check("full_ch_data", ch_data, 32'h13121110);
    check("full_ch_valid", 32'(ch_valid), 32'hF);

    // Sparse mask, changed mid-scan; also the scan period.
    for (int i = 0; i < 4; i++) vals[i] = 8'h20 + 8'(i);
    push_ctrl(8'h01, 2); push_ctrl(8'h03, 2); push_ctrl(8'h00, 2);
    exp_smp_q.push_back({2'd1, 8'h21});
    exp_smp_q.push_back({2'd3, 8'h23});
    exp_smp_q.push_back({2'd0, 8'h20});
    tick_drive(); ch_mask = 4'b1010; enable = 1'b1;
    wait_req(10, c1);
    tick_drive(); ch_mask = 4'b0001;
    wait_scan_done(200, sd);
    wait_req(1100, c2);
    check("scan_period", 32'(c2 - c1), 32'd1000);
    wait_scan_done(200, sd);
    tick_drive(); enable = 1'b0;
    @(negedge clk);
    check("sparse_ch_data", ch_data, 32'h23122120);

    // Timeout on AIN2, AIN3 still sampled.
    for (int i = 0; i < 4; i++) vals[i] = 8'h30 + 8'(i);
    mute_ch = 2;
    push_ctrl(8'h02, 1); push_ctrl(8'h03, 2);
    exp_smp_q.push_back({2'd3, 8'h33});
    tick_drive(); ch_mask = 4'b1100; enable = 1'b1;
    wait_req(10, c1);
    c2 = -1;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (timeout_err) begin
        c2 = cyc;
        break;
      end
    end
    check("timeout_latency", 32'(c2 - c1), 32'd100);
    wait_scan_done(100, sd);
    tick_drive(); enable = 1'b0; mute_ch = -1;
    @(negedge clk);
    check("timeout_err_sticky", 32'(timeout_err), 32'd1);
    check("timeout_ch2_kept", 32'(ch_data[23:16]), 32'h12);
    check("timeout_ch3_stored", 32'(ch_data[31:24]), 32'h33);

    // Reset during WAIT_DONE; discard must be redone after restart.
    lat_a = 20;
    for (int i = 0; i < 4; i++) vals[i] = 8'h40 + 8'(i);
    push_ctrl(8'h00, 3);
    exp_smp_q.push_back({2'd0, 8'h40});
    tick_drive(); ch_mask = 4'b0001; enable = 1'b1;
    wait_req(10, c1);
    repeat (5) tick_drive();
    rst = 1'b1;
    tick_drive(); rst = 1'b0;
    @(negedge clk);
    check_reset("midreset");
    wait_scan_done(200, sd);
    tick_drive(); enable = 1'b0;
    @(negedge clk);
    check("restart_ch_data", ch_data, 32'h00000040);

    // Enable dropped mid-read: the read completes, nothing further issued.
    for (int i = 0; i < 4; i++) vals[i] = 8'h50 + 8'(i);
    push_ctrl(8'h00, 1);
    exp_smp_q.push_back({2'd0, 8'h50});
    tick_drive(); ch_mask = 4'b1111; enable = 1'b1;
    wait_req(10, c1);
    repeat (5) tick_drive();
    enable = 1'b0;
    repeat (100) tick_drive();
    @(negedge clk);
    check("disable_idle", 32'(dbg_state), 32'd0);
    check("disable_ch_data0", 32'(ch_data[7:0]), 32'h50);

    // Spurious adc_done while idle must be ignored.
    inj_req++;
    repeat (5) tick_drive();
    @(negedge clk);
    check("spurious_done_ignored", 32'(ch_data[7:0]), 32'h50);
    check("exp_ctrl_q_empty", 32'(exp_ctrl_q.size()), 32'd0);
    check("exp_smp_q_empty", 32'(exp_smp_q.size()), 32'd0);

    // Overrunning scan: next scan starts 1 cycle after scan_done.
    tick_drive(); rst_b = 1'b0; ch_mask_b = 4'b0011; enable_b = 1'b1;
    c1 = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (scan_done_b) begin
        c1 = cyc;
        break;
      end
    end
    if (c1 < 0) fail_now("slow_scan_done", "no scan_done within 3000 cycles");
    c2 = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (adc_req_b) begin
        c2 = cyc;
        break;
      end
    end
    check("overrun_restart_gap", 32'(c2 - c1), 32'd1);
    check("overrun_ch_valid", 32'(ch_valid_b), 32'h3);
    check("overrun_ch_data", ch_data_b, 32'h00006060);
    seen = timeout_err_b;
    check("overrun_no_timeout", 32'(seen), 32'd0);
    tick_drive(); enable_b = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
